line_timing_gen: RTL

Horizontal/vertical raster counter producing one-CK-wide J/K qualifier pulses for the HSYNC, HBLANK and VBLANK flag flip-flops. It sits directly upstream of the JK flip-flop cells that hold those flags: it drives their J and K inputs, and the flip-flops convert the pulses into level signals. Counting advances only on the pixel clock enable, so the whole video timing chain runs from the single master clock.

---
 rtl/neo_timing_pkg.sv | 20 ++
 rtl/line_timing_gen_mod_counter.sv | 48 ++++
 rtl/line_timing_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/neo_timing_pkg.sv
// Shared video timing constants for the raster counter chain.
//   CNT_W            : width of the horizontal and vertical counters
//   DEF_LINE_LEN     : default pixels per line
//   DEF_FRAME_LEN    : default lines per frame
//   DEF_HS/HB/VB_*   : default set/clear counts for HSYNC, HBLANK and VBLANK
package neo_timing_pkg;

    localparam int unsigned CNT_W         = 9;

    localparam int unsigned DEF_LINE_LEN  = 384;
    localparam int unsigned DEF_FRAME_LEN = 264;

    localparam int unsigned DEF_HS_START  = 344;
    localparam int unsigned DEF_HS_END    = 376;
    localparam int unsigned DEF_HB_START  = 320;
    localparam int unsigned DEF_HB_END    = 8;
    localparam int unsigned DEF_VB_START  = 240;
    localparam int unsigned DEF_VB_END    = 16;

endpackage

// File: rtl/line_timing_gen_mod_counter.sv
// Modulo-N counter used for both raster axes.
//   ck        : master clock
//   nReset    : synchronous active-low reset
//   ce        : count enable
//   clear     : synchronous clear, overrides ce
//   count     : registered count, 0..MODULUS-1
//   nextCount : value count takes on the next edge (combinational)
//   wrap      : count is at MODULUS-1
module mod_counter
    import neo_timing_pkg::*;
#(
    parameter int unsigned MODULUS = DEF_LINE_LEN
) (
    input  logic             ck,
    input  logic             nReset,
    input  logic             ce,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] nextCount,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULUS - 1);

    always_comb begin
        wrap = (count == LAST);
    end

    // Clear is independent of ce so the vertical counter, whose ce is
    // gated by the horizontal wrap, still clears on any enabled resync.
    always_comb begin
        nextCount = count;
        if (clear) begin
            nextCount = '0;
        end else if (ce) begin
            nextCount = wrap ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge ck) begin
        if (!nReset) begin
            count <= '0;
        end else begin
            count <= nextCount;
        end
    end

endmodule

// File: rtl/line_timing_gen.sv
// Raster counter producing one-clock J/K qualifier pulses for the HSYNC,
// HBLANK and VBLANK flag flip-flops.
//   CK          : master clock
//   nRESET      : synchronous active-low reset
//   CE          : pixel clock enable
//   RESYNC      : frame restart request, honoured only when CE=1
//   HCNT, VCNT  : registered horizontal / vertical counts
//   J_xx, K_xx  : set / clear qualifier pulses for the downstream flags
//   LINE_START  : pulse when HCNT enters 0
//   FRAME_START : pulse when (HCNT,VCNT) enters (0,0)
module line_timing_gen
    import neo_timing_pkg::*;
#(
    parameter int unsigned LINE_LEN  = DEF_LINE_LEN,
    parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
    parameter int unsigned HS_START  = DEF_HS_START,
    parameter int unsigned HS_END    = DEF_HS_END,
    parameter int unsigned HB_START  = DEF_HB_START,
    parameter int unsigned HB_END    = DEF_HB_END,
    parameter int unsigned VB_START  = DEF_VB_START,
    parameter int unsigned VB_END    = DEF_VB_END
) (
    input  logic             CK,
    input  logic             nRESET,
    input  logic             CE,
    input  logic             RESYNC,
    output logic [CNT_W-1:0] HCNT,
    output logic [CNT_W-1:0] VCNT,
    output logic             J_HS,
    output logic             K_HS,
    output logic             J_HB,
    output logic             K_HB,
    output logic             J_VB,
    output logic             K_VB,
    output logic             LINE_START,
    output logic             FRAME_START
);

    if (LINE_LEN > (1 << CNT_W) || FRAME_LEN > (1 << CNT_W)) begin : gBadLen
        $error("line_timing_gen: LINE_LEN/FRAME_LEN exceed counter range");
    end
    if (HS_START >= LINE_LEN || HS_END >= LINE_LEN || HB_START >= LINE_LEN ||
        HB_END >= LINE_LEN || VB_START >= FRAME_LEN || VB_END >= FRAME_LEN) begin : gBadPos
        $error("line_timing_gen: START/END value out of range");
    end
    if (HS_START == HS_END || HB_START == HB_END || VB_START == VB_END) begin : gBadPair
        $error("line_timing_gen: START equals END within a pair");
    end

    localparam logic [CNT_W-1:0] HS_SET = CNT_W'(HS_START);
    localparam logic [CNT_W-1:0] HS_CLR = CNT_W'(HS_END);
    localparam logic [CNT_W-1:0] HB_SET = CNT_W'(HB_START);
    localparam logic [CNT_W-1:0] HB_CLR = CNT_W'(HB_END);
    localparam logic [CNT_W-1:0] VB_SET = CNT_W'(VB_START);
    localparam logic [CNT_W-1:0] VB_CLR = CNT_W'(VB_END);

    logic [CNT_W-1:0] nH;
    logic [CNT_W-1:0] nV;
    logic             wrapH;
    logic             vWrapUnused;
    logic             resyncEn;
    logic             vCe;

    always_comb begin
        resyncEn = CE & RESYNC;
        vCe      = CE & wrapH;
    end

    mod_counter #(.MODULUS(LINE_LEN)) uHCount (
        .ck        (CK),
        .nReset    (nRESET),
        .ce        (CE),
        .clear     (resyncEn),
        .count     (HCNT),
        .nextCount (nH),
        .wrap      (wrapH)
    );

    mod_counter #(.MODULUS(FRAME_LEN)) uVCount (
        .ck        (CK),
        .nReset    (nRESET),
        .ce        (vCe),
        .clear     (resyncEn),
        .count     (VCNT),
        .nextCount (nV),
        .wrap      (vWrapUnused)
    );

    // Decoding the next counts means each pulse lines up with the first
    // cycle the counters show the trigger value.
    always_ff @(posedge CK) begin
        if (!nRESET || !CE) begin
            J_HS        <= 1'b0;
            K_HS        <= 1'b0;
            J_HB        <= 1'b0;
            K_HB        <= 1'b0;
            J_VB        <= 1'b0;
            K_VB        <= 1'b0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            J_HS        <= (nH == HS_SET);
            K_HS        <= (nH == HS_CLR);
            J_HB        <= (nH == HB_SET);
            K_HB        <= (nH == HB_CLR);
            J_VB        <= (nH == '0) && (nV == VB_SET);
            K_VB        <= (nH == '0) && (nV == VB_CLR);
            LINE_START  <= (nH == '0);
            FRAME_START <= (nH == '0) && (nV == '0);
        end
    end

endmodule
